el2_lsu_trigger_hit: RTL

//  Downstream consumer of the LSU per-trigger M-stage match vector. Applies pair chaining,

---
 rtl/el2_lsu_trigger_hit.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/el2_lsu_trigger_hit.sv
// LSU trigger-hit consumer: pair chaining, M->R register, TLU debug/exception request, sticky hits.
// Optional saturating per-trigger hit counters are compiled in with RV_LSU_TRIG_HIT_CNT_EN.
module el2_lsu_trigger_hit #(
    parameter int NUM_TRIG = 4,
    parameter int CNT_W    = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_TRIG-1:0]        lsu_trigger_match_m,
    input  logic [NUM_TRIG-1:0]        trig_chain,
    input  logic [NUM_TRIG-1:0]        trig_action,
    input  logic                       dec_tlu_flush_lower_r,
    input  logic                       dec_trig_ack,
    input  logic [NUM_TRIG-1:0]        trig_hit_clr,
    output logic [NUM_TRIG-1:0]        lsu_trig_match_r,
    output logic                       lsu_trig_dbg_req,
    output logic                       lsu_trig_exc_req,
    output logic [NUM_TRIG-1:0]        lsu_trig_req_vec,
    output logic [NUM_TRIG-1:0]        lsu_trig_hit_sticky,
    output logic [NUM_TRIG*CNT_W-1:0]  lsu_trig_hit_cnt
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] PEND_DBG = 2'd1;
    localparam logic [1:0] PEND_EXC = 2'd2;

    logic [NUM_TRIG-1:0] eff_match_p0;
    logic [NUM_TRIG-1:0] hit_set_p1;
    logic [NUM_TRIG-1:0] req_vec_nxt;
    logic [1:0]          state_p1;
    logic [1:0]          state_nxt;
    logic                hit_r;
    logic                dbg_hit;
    logic                unused_chain;

    // Only the even chain bits link a pair; the odd ones carry no meaning here.
    assign unused_chain = trig_chain[1] ^ trig_chain[3];

    // M stage: a chained pair fires only when both halves match.
    always_comb begin
        eff_match_p0 = lsu_trigger_match_m;
        if (trig_chain[0]) begin
            eff_match_p0[0] = lsu_trigger_match_m[0] & lsu_trigger_match_m[1];
            eff_match_p0[1] = lsu_trigger_match_m[0] & lsu_trigger_match_m[1];
        end
        if (trig_chain[2]) begin
            eff_match_p0[2] = lsu_trigger_match_m[2] & lsu_trigger_match_m[3];
            eff_match_p0[3] = lsu_trigger_match_m[2] & lsu_trigger_match_m[3];
        end
    end

    // M -> R register
    always_ff @(posedge clk) begin
        if (rst) begin
            lsu_trig_match_r <= '0;
        end else begin
            lsu_trig_match_r <= dec_tlu_flush_lower_r ? '0 : eff_match_p0;
        end
    end

    assign hit_r      = (|lsu_trig_match_r) & ~dec_tlu_flush_lower_r;
    assign dbg_hit    = |(lsu_trig_match_r & trig_action);
    assign hit_set_p1 = hit_r ? lsu_trig_match_r : '0;

    // Request FSM: a hit is only taken when idle or when the pending one is acked.
    always_comb begin
        state_nxt   = state_p1;
        req_vec_nxt = lsu_trig_req_vec;
        case (state_p1)
            IDLE: begin
                if (hit_r) begin
                    state_nxt   = dbg_hit ? PEND_DBG : PEND_EXC;
                    req_vec_nxt = lsu_trig_match_r;
                end
            end
            PEND_DBG, PEND_EXC: begin
                if (dec_trig_ack) begin
                    if (hit_r) begin
                        state_nxt   = dbg_hit ? PEND_DBG : PEND_EXC;
                        req_vec_nxt = lsu_trig_match_r;
                    end else begin
                        state_nxt   = IDLE;
                        req_vec_nxt = '0;
                    end
                end
            end
            default: begin
                state_nxt   = IDLE;
                req_vec_nxt = '0;
            end
        endcase
    end

    // R stage state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_p1            <= IDLE;
            lsu_trig_req_vec    <= '0;
            lsu_trig_hit_sticky <= '0;
        end else begin
            state_p1            <= state_nxt;
            lsu_trig_req_vec    <= req_vec_nxt;
            lsu_trig_hit_sticky <= (lsu_trig_hit_sticky & ~trig_hit_clr) | hit_set_p1;
        end
    end

    assign lsu_trig_dbg_req = (state_p1 == PEND_DBG);
    assign lsu_trig_exc_req = (state_p1 == PEND_EXC);

`ifdef RV_LSU_TRIG_HIT_CNT_EN
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic [CNT_W-1:0] hit_cnt_p1 [NUM_TRIG];

    // A clear coinciding with a hit restarts the count at one.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_TRIG; i++) begin
            if (rst) begin
                hit_cnt_p1[i] <= '0;
            end else if (trig_hit_clr[i]) begin
                hit_cnt_p1[i] <= {{(CNT_W-1){1'b0}}, hit_set_p1[i]};
            end else if (hit_set_p1[i]) begin
                hit_cnt_p1[i] <= sat_inc(hit_cnt_p1[i]);
            end
        end
    end

    always_comb begin
        lsu_trig_hit_cnt = '0;
        for (int i = 0; i < NUM_TRIG; i++) begin
            lsu_trig_hit_cnt[i*CNT_W +: CNT_W] = hit_cnt_p1[i];
        end
    end
`else
    assign lsu_trig_hit_cnt = '0;
`endif

endmodule
